// File: rtl/riscv_pkg.sv
// Shared encodings for the EX-stage RV32M multiply/divide unit: funct3 codes,
// forwarding selects and the multiply/divide FSM state type.
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 6;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

endpackage

// File: rtl/ex_operand_mux.sv
// Combinational forwarding select for one EX-stage operand: ID/EX register
// value, EX/MEM ALU result or MEM/WB writeback data.
module ex_operand_mux #(
  parameter int XLEN = 32
) (
  input  logic [1:0]      fwd_sel_i,
  input  logic [XLEN-1:0] reg_data_i,
  input  logic [XLEN-1:0] mem_data_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic [XLEN-1:0] operand_o
);
  import riscv_pkg::*;

  // Select the freshest copy of the operand; the unused code falls back to ID/EX.
  always_comb begin
    operand_o = reg_data_i;
    case (fwd_sel_i)
      FWD_REG: operand_o = reg_data_i;
      FWD_MEM: operand_o = mem_data_i;
      FWD_WB:  operand_o = wb_data_i;
      default: operand_o = reg_data_i;
    endcase
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit in EX with forwarding and pipeline stall.
// Optional build macro MULDIV_FAST_MUL_EN: single-cycle multiplies.
module ex_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [1:0]      forwardA,
  input  logic [1:0]      forwardB,
  input  logic [XLEN-1:0] rs1_data_ex,
  input  logic [XLEN-1:0] rs2_data_ex,
  input  logic [XLEN-1:0] alu_result_mem,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall_req,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);
  import riscv_pkg::*;

  localparam logic [XLEN-1:0]   ONE_X  = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [2*XLEN-1:0] ONE_2X = {{(2*XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]   MIN_X  = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] rq_q, rq_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              valid_q, valid_d;

  logic [XLEN-1:0]   op_a_s, op_b_s;
  logic              a_signed_s, b_signed_s, a_neg_s, b_neg_s, neg_res_s;
  logic [XLEN-1:0]   a_abs_s, b_abs_s;
  logic              div_zero_s, ovf_s, special_s;
  logic [XLEN-1:0]   special_res_s;
  logic [XLEN:0]     mul_sum_s;
  logic [XLEN:0]     div_part_s;
  logic              div_ge_s;
  logic [XLEN-1:0]   div_diff_s;
  logic [2*XLEN-1:0] step_s, prod_s;
  logic [XLEN-1:0]   div_sel_s, div_fix_s, fix_res_s;

  ex_operand_mux #(.XLEN(XLEN)) u_mux_a (
    .fwd_sel_i  (forwardA),
    .reg_data_i (rs1_data_ex),
    .mem_data_i (alu_result_mem),
    .wb_data_i  (wb_data),
    .operand_o  (op_a_s)
  );

  ex_operand_mux #(.XLEN(XLEN)) u_mux_b (
    .fwd_sel_i  (forwardB),
    .reg_data_i (rs2_data_ex),
    .mem_data_i (alu_result_mem),
    .wb_data_i  (wb_data),
    .operand_o  (op_b_s)
  );

  assign a_signed_s = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                      (funct3 == F3_DIV)  || (funct3 == F3_REM);
  assign b_signed_s = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
  assign a_neg_s    = a_signed_s & op_a_s[XLEN-1];
  assign b_neg_s    = b_signed_s & op_b_s[XLEN-1];
  assign a_abs_s    = a_neg_s ? (~op_a_s + ONE_X) : op_a_s;
  assign b_abs_s    = b_neg_s ? (~op_b_s + ONE_X) : op_b_s;
  // Remainder takes the dividend's sign; products and quotients the XOR of both.
  assign neg_res_s  = (funct3 == F3_REM) ? a_neg_s : (a_neg_s ^ b_neg_s);

  assign div_zero_s = funct3[2] & (op_b_s == {XLEN{1'b0}});
  assign ovf_s      = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                      (op_a_s == MIN_X) && (op_b_s == {XLEN{1'b1}});

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a_s, fast_b_s, fast_prod_s;
  assign fast_a_s    = {{XLEN{a_neg_s}}, op_a_s};
  assign fast_b_s    = {{XLEN{b_neg_s}}, op_b_s};
  assign fast_prod_s = fast_a_s * fast_b_s;
  assign special_s   = div_zero_s | ovf_s | ~funct3[2];
`else
  assign special_s   = div_zero_s | ovf_s;
`endif

  // Result for operations that complete straight from IDLE.
  always_comb begin
    special_res_s = {XLEN{1'b0}};
    if (div_zero_s) begin
      special_res_s = funct3[1] ? op_a_s : {XLEN{1'b1}};
    end else if (ovf_s) begin
      special_res_s = funct3[1] ? {XLEN{1'b0}} : MIN_X;
    end else begin
`ifdef MULDIV_FAST_MUL_EN
      special_res_s = (funct3 == F3_MUL) ? fast_prod_s[XLEN-1:0] : fast_prod_s[2*XLEN-1:XLEN];
`else
      special_res_s = {XLEN{1'b0}};
`endif
    end
  end

  // rq_q holds {accumulator, multiplier} for multiply and {remainder, quotient} for divide.
  assign mul_sum_s  = {1'b0, rq_q[2*XLEN-1:XLEN]} +
                      (rq_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
  assign div_part_s = rq_q[2*XLEN-1:XLEN-1];
  assign div_ge_s   = (div_part_s >= {1'b0, b_q});
  assign div_diff_s = div_part_s[XLEN-1:0] - b_q;
  assign step_s     = f3_q[2] ?
                      (div_ge_s ? {div_diff_s, rq_q[XLEN-2:0], 1'b1}
                                : {div_part_s[XLEN-1:0], rq_q[XLEN-2:0], 1'b0}) :
                      {mul_sum_s, rq_q[XLEN-1:1]};

  assign prod_s     = neg_q ? (~step_s + ONE_2X) : step_s;
  assign div_sel_s  = f3_q[1] ? step_s[2*XLEN-1:XLEN] : step_s[XLEN-1:0];
  assign div_fix_s  = neg_q ? (~div_sel_s + ONE_X) : div_sel_s;
  assign fix_res_s  = f3_q[2] ? div_fix_s :
                      ((f3_q == F3_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]);

  // Next-state, datapath and result update; flush overrides everything else.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rq_d     = rq_q;
    b_d      = b_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    result_d = result_q;
    valid_d  = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            f3_d  = funct3;
            neg_d = neg_res_s;
            b_d   = b_abs_s;
            rq_d  = {{XLEN{1'b0}}, a_abs_s};
            cnt_d = {CNT_W{1'b0}};
            if (special_s) begin
              state_d  = DONE;
              result_d = special_res_s;
              valid_d  = 1'b1;
            end else begin
              state_d = BUSY;
            end
          end else begin
            state_d = IDLE;
          end
        end
        BUSY: begin
          rq_d  = step_s;
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_q == CNT_W'(XLEN-1)) begin
            state_d  = DONE;
            result_d = fix_res_s;
            valid_d  = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      rq_q     <= {(2*XLEN){1'b0}};
      b_q      <= {XLEN{1'b0}};
      f3_q     <= 3'd0;
      neg_q    <= 1'b0;
      result_q <= {XLEN{1'b0}};
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rq_q     <= rq_d;
      b_q      <= b_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign stall_req    = reset_n & ((((state_q == IDLE) & start) & ~flush) | (state_q == BUSY));
  assign busy         = (state_q != IDLE);
  assign result_valid = valid_q;
  assign result       = result_q;

endmodule
